// File: rtl/game_sprite_mover_pkg.sv
// Shared geometry, widths and types for the sprite position/velocity engine.
package game_sprite_mover_pkg;

    localparam int unsigned SCREEN_W       = 640;
    localparam int unsigned SCREEN_H       = 480;
    localparam int unsigned X_WIDTH        = 10;
    localparam int unsigned Y_WIDTH        = 10;
    localparam int unsigned DXY_WIDTH      = 3;
    localparam int unsigned DEF_SPRITE_W   = 8;
    localparam int unsigned DEF_SPRITE_H   = 8;
    localparam int unsigned DEF_UPDATE_DIV = 2;

    typedef logic signed [X_WIDTH:0]     xpos_t;
    typedef logic signed [Y_WIDTH:0]     ypos_t;
    typedef logic signed [DXY_WIDTH-1:0] dxy_t;
    typedef logic signed [X_WIDTH+1:0]   xcmp_t;
    typedef logic signed [Y_WIDTH+1:0]   ycmp_t;
    typedef logic [X_WIDTH-1:0]          xpix_t;
    typedef logic [Y_WIDTH-1:0]          ypix_t;

    // True when a sw x sh box anchored at (x,y) lies entirely on the visible screen.
    function automatic logic box_on_screen(xpos_t x, ypos_t y, int unsigned sw, int unsigned sh);
        xcmp_t xs;
        ycmp_t ys;
        xs = xcmp_t'(x);
        ys = ycmp_t'(y);
        return !xs[X_WIDTH+1] && (xs <= xcmp_t'(SCREEN_W - sw)) &&
               !ys[Y_WIDTH+1] && (ys <= ycmp_t'(SCREEN_H - sh));
    endfunction

endpackage

// File: rtl/game_sprite_mover_if.sv
// Control strobes, start values, pixel probe and results between the game FSM and one sprite.
interface game_sprite_mover_if;
    import game_sprite_mover_pkg::*;

    logic  frame_strobe;
    logic  write_xy;
    xpos_t x_in;
    ypos_t y_in;
    logic  write_dxy;
    dxy_t  dx_in;
    dxy_t  dy_in;
    logic  enable_update;
    xpix_t pixel_x;
    ypix_t pixel_y;
    xpos_t x;
    ypos_t y;
    logic  within_screen;
    logic  moved;
    logic  hit;

    modport master (
        output frame_strobe, write_xy, x_in, y_in, write_dxy, dx_in, dy_in,
               enable_update, pixel_x, pixel_y,
        input  x, y, within_screen, moved, hit
    );

    modport slave (
        input  frame_strobe, write_xy, x_in, y_in, write_dxy, dx_in, dy_in,
               enable_update, pixel_x, pixel_y,
        output x, y, within_screen, moved, hit
    );

endinterface

// File: rtl/game_sprite_mover_hit.sv
// Registered pixel-in-bounding-box comparator; shared with the collision detector.
module game_sprite_hit
    import game_sprite_mover_pkg::*;
#(
    parameter int unsigned SPRITE_W = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H = DEF_SPRITE_H
) (
    input  logic  clk,
    input  logic  reset_n,
    input  xpos_t x_i,
    input  ypos_t y_i,
    input  xpix_t pixel_x_i,
    input  ypix_t pixel_y_i,
    output logic  hit_o
);

    xcmp_t px, xs;
    ycmp_t py, ys;
    logic  hit_d, hit_q;

    // Pixel coordinates are zero-extended, positions sign-extended, so an off-screen box never matches.
    always_comb begin
        px    = xcmp_t'({2'b00, pixel_x_i});
        py    = ycmp_t'({2'b00, pixel_y_i});
        xs    = xcmp_t'(x_i);
        ys    = ycmp_t'(y_i);
        hit_d = (px >= xs) && (px < xs + xcmp_t'(SPRITE_W)) &&
                (py >= ys) && (py < ys + ycmp_t'(SPRITE_H));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) hit_q <= 1'b0;
        else          hit_q <= hit_d;
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/game_sprite_mover.sv
// Per-sprite position/velocity engine: divided frame-rate stepping, freeze when off screen.
module game_sprite_mover
    import game_sprite_mover_pkg::*;
#(
    parameter int unsigned SPRITE_W   = DEF_SPRITE_W,
    parameter int unsigned SPRITE_H   = DEF_SPRITE_H,
    parameter int unsigned UPDATE_DIV = DEF_UPDATE_DIV
) (
    input  logic                clk,
    input  logic                reset_n,
    game_sprite_mover_if.slave  bus
);

    localparam int unsigned CW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(UPDATE_DIV - 1);

    xpos_t         x_q, x_d;
    ypos_t         y_q, y_d;
    dxy_t          dx_q, dx_d, dy_q, dy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          within_q, within_d;
    logic          moved_q, moved_d;
    logic          advance, step;
    logic          hit;

    // A load always wins over a due step and restarts the divider.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        cnt_d    = cnt_q;
        advance  = bus.frame_strobe && bus.enable_update && within_q;
        step     = advance && (cnt_q == CNT_LAST) && !bus.write_xy;

        if (!bus.enable_update || bus.write_xy) cnt_d = '0;
        else if (advance)                       cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

        if (bus.write_xy) begin
            x_d = bus.x_in;
            y_d = bus.y_in;
        end else if (step) begin
            x_d = x_q + xpos_t'(dx_q);
            y_d = y_q + ypos_t'(dy_q);
        end

        if (bus.write_dxy) begin
            dx_d = bus.dx_in;
            dy_d = bus.dy_in;
        end

        moved_d  = step;
        within_d = box_on_screen(x_d, y_d, SPRITE_W, SPRITE_H);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            cnt_q    <= '0;
            within_q <= 1'b1;
            moved_q  <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            cnt_q    <= cnt_d;
            within_q <= within_d;
            moved_q  <= moved_d;
        end
    end

    game_sprite_hit #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_hit (
        .clk       (clk),
        .reset_n   (reset_n),
        .x_i       (x_q),
        .y_i       (y_q),
        .pixel_x_i (bus.pixel_x),
        .pixel_y_i (bus.pixel_y),
        .hit_o     (hit)
    );

    assign bus.x             = x_q;
    assign bus.y             = y_q;
    assign bus.within_screen = within_q;
    assign bus.moved         = moved_q;
    assign bus.hit           = hit;

endmodule

// File: tb/tb_game_sprite_mover.sv
// Drives two movers (UPDATE_DIV 1 and 2) with shared stimulus against a behavioural model.
module tb_game_sprite_mover;
    import game_sprite_mover_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic  fs = 1'b0, wxy = 1'b0, wdxy = 1'b0, en = 1'b0;
    xpos_t xin = '0;
    ypos_t yin = '0;
    dxy_t  dxin = '0, dyin = '0;
    xpix_t pxi = '0;
    ypix_t pyi = '0;

    game_sprite_mover_if bus1 ();
    game_sprite_mover_if bus2 ();

    assign bus1.frame_strobe = fs;   assign bus2.frame_strobe = fs;
    assign bus1.write_xy = wxy;      assign bus2.write_xy = wxy;
    assign bus1.x_in = xin;          assign bus2.x_in = xin;
    assign bus1.y_in = yin;          assign bus2.y_in = yin;
    assign bus1.write_dxy = wdxy;    assign bus2.write_dxy = wdxy;
    assign bus1.dx_in = dxin;        assign bus2.dx_in = dxin;
    assign bus1.dy_in = dyin;        assign bus2.dy_in = dyin;
    assign bus1.enable_update = en;  assign bus2.enable_update = en;
    assign bus1.pixel_x = pxi;       assign bus2.pixel_x = pxi;
    assign bus1.pixel_y = pyi;       assign bus2.pixel_y = pyi;

    game_sprite_mover #(.SPRITE_W(8), .SPRITE_H(8), .UPDATE_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));
    game_sprite_mover #(.SPRITE_W(8), .SPRITE_H(8), .UPDATE_DIV(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position advances on every DIV-th qualifying strobe counted since the last launch.
    int mx[2], my[2], mdx[2], mdy[2], mtally[2];
    int mwin[2], mmov[2], mhit[2];
    int divs[2] = '{1, 2};

    function automatic int on_screen(int x, int y);
        return (x >= 0 && x <= 640 - 8 && y >= 0 && y <= 480 - 8) ? 1 : 0;
    endfunction

    task automatic model_edge(input int i);
        int px, py;
        px = int'(pxi);
        py = int'(pyi);
        if (!reset_n) begin
            mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; mtally[i] = 0;
            mwin[i] = 1; mmov[i] = 0; mhit[i] = 0;
            return;
        end
        mhit[i] = (px >= mx[i] && px < mx[i] + 8 && py >= my[i] && py < my[i] + 8) ? 1 : 0;
        mmov[i] = 0;
        if (wxy) begin
            mx[i] = int'(xin); my[i] = int'(yin); mtally[i] = 0;
        end else if (!en) begin
            mtally[i] = 0;
        end else if (fs && mwin[i] == 1) begin
            mtally[i]++;
            if (mtally[i] % divs[i] == 0) begin
                mx[i] += mdx[i]; my[i] += mdy[i]; mmov[i] = 1;
            end
        end
        if (wdxy) begin
            mdx[i] = int'(dxin); mdy[i] = int'(dyin);
        end
        mwin[i] = on_screen(mx[i], my[i]);
    endtask

    task automatic cmp_inst(input int i, input int x, input int y, input int w, input int m, input int h);
        chk($sformatf("x[div%0d]", divs[i]), x, mx[i]);
        chk($sformatf("y[div%0d]", divs[i]), y, my[i]);
        chk($sformatf("within[div%0d]", divs[i]), w, mwin[i]);
        chk($sformatf("moved[div%0d]", divs[i]), m, mmov[i]);
        chk($sformatf("hit[div%0d]", divs[i]), h, mhit[i]);
    endtask

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
        #1;
        cmp_inst(0, int'(bus1.x), int'(bus1.y), int'(bus1.within_screen), int'(bus1.moved), int'(bus1.hit));
        cmp_inst(1, int'(bus2.x), int'(bus2.y), int'(bus2.within_screen), int'(bus2.moved), int'(bus2.hit));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input int x, input int y, input int dx, input int dy);
        wxy = 1'b1; xin = xpos_t'(x); yin = ypos_t'(y);
        wdxy = 1'b1; dxin = dxy_t'(dx); dyin = dxy_t'(dy);
        en = 1'b1;
        cyc();
        wxy = 1'b0; wdxy = 1'b0;
    endtask

    // One strobe; leaves the bench one negedge after the edge that consumed it.
    task automatic strobe();
        fs = 1'b1;
        cyc();
        fs = 1'b0;
    endtask

    initial begin
        int pulses;
        int ex1[5] = '{631, 632, 633, 633, 633};
        int ew1[5] = '{1, 1, 0, 0, 0};
        int em1[5] = '{1, 1, 1, 0, 0};

        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fs = 1'($urandom); wxy = 1'($urandom); wdxy = 1'($urandom); en = 1'($urandom);
            xin = xpos_t'($urandom); yin = ypos_t'($urandom);
            pxi = xpix_t'($urandom_range(100, 1023)); pyi = ypix_t'($urandom_range(100, 1023));
            cyc();
        end
        chk("reset_x", int'(bus2.x), 0);
        chk("reset_y", int'(bus2.y), 0);
        chk("reset_within", int'(bus2.within_screen), 1);
        chk("reset_moved", int'(bus2.moved), 0);
        chk("reset_hit", int'(bus2.hit), 0);
        fs = 0; wxy = 0; wdxy = 0; en = 0;
        reset_n = 1'b1;
        cyc();

        // Basic motion at divide-by-2
        load(100, 200, 2, -1);
        pulses = 0;
        for (int s = 1; s <= 4; s++) begin
            strobe();
            if (bus2.moved) pulses++;
            chk("basic_moved", int'(bus2.moved), (s % 2 == 0) ? 1 : 0);
            if (s == 2) begin
                chk("basic_x2", int'(bus2.x), 102);
                chk("basic_y2", int'(bus2.y), 199);
            end
            if (s == 4) begin
                chk("basic_x4", int'(bus2.x), 104);
                chk("basic_y4", int'(bus2.y), 198);
            end
            cyc();
            if (bus2.moved) pulses++;
            chk("basic_moved_width", int'(bus2.moved), 0);
        end
        chk("basic_pulses", pulses, 2);

        // Right-edge exit and freeze at divide-by-1
        load(630, 10, 1, 0);
        for (int s = 0; s < 5; s++) begin
            strobe();
            chk("edge_x", int'(bus1.x), ex1[s]);
            chk("edge_within", int'(bus1.within_screen), ew1[s]);
            chk("edge_moved", int'(bus1.moved), em1[s]);
            cyc();
        end

        // Load coincident with a due step at divide-by-2
        load(10, 10, 1, 1);
        strobe();
        fs = 1'b1; wxy = 1'b1; xin = 50; yin = 50;
        cyc();
        fs = 1'b0; wxy = 1'b0;
        chk("coinc_x", int'(bus2.x), 50);
        chk("coinc_y", int'(bus2.y), 50);
        chk("coinc_moved", int'(bus2.moved), 0);
        strobe();
        chk("coinc_cleared_x", int'(bus2.x), 50);
        strobe();
        chk("coinc_next_x", int'(bus2.x), 51);

        // Velocity load coincident with a step at divide-by-1
        load(100, 100, 1, 0);
        fs = 1'b1; wdxy = 1'b1; dxin = -3; dyin = 0;
        cyc();
        fs = 1'b0; wdxy = 1'b0;
        chk("dxy_old_step", int'(bus1.x), 101);
        strobe();
        chk("dxy_new_step", int'(bus1.x), 98);

        // Negative exit
        load(1, 5, -2, 0);
        strobe();
        chk("neg_x", int'(bus1.x), -1);
        chk("neg_within", int'(bus1.within_screen), 0);
        strobe();
        chk("neg_frozen_x", int'(bus1.x), -1);
        chk("neg_frozen_moved", int'(bus1.moved), 0);

        // Hit window
        load(20, 30, 0, 0);
        en = 1'b0;
        pxi = 20; pyi = 30; cyc(); chk("hit_20_30", int'(bus1.hit), 1);
        pxi = 27; pyi = 37; cyc(); chk("hit_27_37", int'(bus1.hit), 1);
        pxi = 28; pyi = 30; cyc(); chk("hit_28_30", int'(bus1.hit), 0);
        pxi = 19; pyi = 30; cyc(); chk("hit_19_30", int'(bus2.hit), 0);

        // Randomised traffic, including occasional mid-motion resets
        for (int n = 0; n < 4000; n++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            fs      = ($urandom_range(0, 3) == 0);
            wxy     = ($urandom_range(0, 49) == 0);
            wdxy    = ($urandom_range(0, 19) == 0);
            en      = ($urandom_range(0, 9) != 0);
            xin     = xpos_t'($urandom_range(0, 760) - 50);
            yin     = ypos_t'($urandom_range(0, 580) - 50);
            dxin    = dxy_t'($urandom);
            dyin    = dxy_t'($urandom);
            if ($urandom_range(0, 1) == 0 && mx[1] >= 4 && my[1] >= 4 && mx[1] < 1000 && my[1] < 1000) begin
                pxi = xpix_t'(mx[1] - 4 + $urandom_range(0, 15));
                pyi = ypix_t'(my[1] - 4 + $urandom_range(0, 15));
            end else begin
                pxi = xpix_t'($urandom);
                pyi = ypix_t'($urandom);
            end
            cyc();
        end
        reset_n = 1'b1;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
